// File: rtl/zxspi_host.sv
// zxspi_host - SPI host for the Z80 I/O bus.
//
// Three I/O ports are decoded from the low address byte:
//   PORT_CS   (write) : chip-select register, d[CSN-1:0] -> cs (active-low)
//   PORT_DATA (rd/wr) : write sends d; read returns the last received byte
//                       and then clocks out 8'hFF to fetch the next one
//   PORT_CTRL (rd/wr) : write sets the SCK divider (and cpol when enabled);
//                       read returns {busy, ovr, cpol, 0, div[3:0]}
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   ce                CPU clock enable qualifying every bus sample
//   enable            0 forces all chip selects high and ignores CS writes
//   iorq, rd, wr      Z80 bus strobes, active-low
//   a, d, q           low address byte, write data, read data
//   cs                active-low chip selects (CSN of them)
//   ck, mosi, miso    SPI lines, MSB first, sampling on the leading edge
//
// Optional feature: define SPI_CPOL_EN to make bit 7 of a control write
// select the SCK idle level (SPI modes 0 and 2). Without it ck idles low.

module zxspi_host #(
  parameter int         CSN       = 2,
  parameter logic [7:0] PORT_CS   = 8'hE7,
  parameter logic [7:0] PORT_DATA = 8'hEB,
  parameter logic [7:0] PORT_CTRL = 8'hE3,
  parameter int         DIVW      = 4,
  parameter int         DIV_INIT  = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  input  logic           enable,
  input  logic           iorq,
  input  logic           rd,
  input  logic           wr,
  input  logic [7:0]     a,
  input  logic [7:0]     d,
  output logic [7:0]     q,
  output logic [CSN-1:0] cs,
  output logic           ck,
  output logic           mosi,
  input  logic           miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LEAD,
    S_TRAIL,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic            acc_cs, acc_data, acc_ctrl;
  logic            acc_cs_q, acc_data_q, acc_ctrl_q;
  logic            stb_cs, stb_data, stb_ctrl;
  logic [CSN-1:0]  cs_reg;
  logic [DIVW-1:0] div;
  logic [DIVW-1:0] dcnt;
  logic [2:0]      bitcnt;
  logic [7:0]      txs;
  logic [7:0]      rxs;
  logic [7:0]      rx;
  logic            busy;
  logic            ovr;
  logic            ck_r;
  logic            cpol;
  logic [3:0]      div4;
  logic            tick;
  logic            start;

  assign acc_cs   = !iorq && (a == PORT_CS)   && (!rd || !wr);
  assign acc_data = !iorq && (a == PORT_DATA) && (!rd || !wr);
  assign acc_ctrl = !iorq && (a == PORT_CTRL) && (!rd || !wr);

  // Rising-edge detect on the access terms so that an I/O cycle stretched
  // by wait states still produces exactly one action.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cs_q   <= 1'b0;
      acc_data_q <= 1'b0;
      acc_ctrl_q <= 1'b0;
    end else if (ce) begin
      acc_cs_q   <= acc_cs;
      acc_data_q <= acc_data;
      acc_ctrl_q <= acc_ctrl;
    end
  end

  assign stb_cs   = ce && acc_cs   && !acc_cs_q;
  assign stb_data = ce && acc_data && !acc_data_q;
  assign stb_ctrl = ce && acc_ctrl && !acc_ctrl_q;

  // busy stays high through DONE, so a data strobe landing on the final
  // clock of a transfer is treated as an overrun rather than a new start.
  assign start = stb_data && !busy;
  assign tick  = (dcnt == div);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SETUP;
      S_SETUP: state_nx = S_LEAD;
      S_LEAD:  if (tick) state_nx = S_TRAIL;
      S_TRAIL: if (tick) state_nx = (bitcnt == 3'd0) ? S_DONE : S_LEAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus-side registers and the bit engine datapath. The receive shifter
  // takes miso on the leading edge; the transmit shifter advances on the
  // trailing edge so mosi is stable for a full half period before sampling.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_reg <= '1;
      div    <= DIVW'(DIV_INIT);
      dcnt   <= '0;
      bitcnt <= 3'd0;
      txs    <= 8'hFF;
      rxs    <= 8'h00;
      rx     <= 8'hFF;
      busy   <= 1'b0;
      ovr    <= 1'b0;
      ck_r   <= 1'b0;
      mosi   <= 1'b1;
    end else begin
      if (stb_cs && !wr && enable)
        cs_reg <= d[CSN-1:0];

      if (stb_ctrl) begin
        if (!wr) begin
          if (busy) ovr <= 1'b1;
          else      div <= d[DIVW-1:0];
        end else begin
          ovr <= 1'b0;
        end
      end

      if (stb_data) begin
        if (busy) begin
          ovr <= 1'b1;
        end else begin
          busy <= 1'b1;
          txs  <= !wr ? d : 8'hFF;
        end
      end

      case (state)
        S_SETUP: begin
          mosi   <= txs[7];
          bitcnt <= 3'd7;
          dcnt   <= '0;
        end
        S_LEAD: begin
          if (tick) begin
            ck_r <= 1'b1;
            rxs  <= {rxs[6:0], miso};
            dcnt <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            ck_r   <= 1'b0;
            txs    <= {txs[6:0], 1'b1};
            mosi   <= txs[6];
            bitcnt <= bitcnt - 3'd1;
            dcnt   <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_DONE: begin
          rx   <= rxs;
          busy <= 1'b0;
          mosi <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_CPOL_EN
  // Clock polarity follows bit 7 of an accepted control write.
  always_ff @(posedge clock) begin
    if (reset)
      cpol <= 1'b0;
    else if (stb_ctrl && !wr && !busy)
      cpol <= d[7];
  end
`else
  assign cpol = 1'b0;
`endif

  // ck_r is the "active" phase; polarity is applied only at the pin.
  assign ck   = ck_r ^ cpol;
  assign cs   = enable ? cs_reg : '1;
  assign div4 = 4'(div);

  // The chip-select register is write-only, so its address reads as 8'hFF
  // like any undecoded port.
  always_comb begin
    q = 8'hFF;
    if (a == PORT_DATA)
      q = rx;
    else if (a == PORT_CTRL)
      q = {busy, ovr, cpol, 1'b0, div4};
  end

endmodule
